// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file and ALU.
// Sequenced cycle-by-cycle by the control FSM through the i_* strobes.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned RF_DEPTH = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_iord,
  input  logic        i_memwrite,
  input  logic        i_irwrite,
  input  logic        i_pcwrite,
  input  logic        i_branch,
  input  logic [1:0]  i_pcsrc,
  input  logic        i_regdst,
  input  logic        i_memtoreg,
  input  logic [1:0]  i_aluop,
  input  logic        i_alusrca,
  input  logic [1:0]  i_alusrcb,
  input  logic        i_regwrite,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic [5:0]  o_opcode,
  output logic        o_zero,
  output logic [31:0] o_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] mdr_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] aluout_q;
  logic [XLEN-1:0] rf [RF_DEPTH];

  logic [RIDX-1:0] rs;
  logic [RIDX-1:0] rt;
  logic [RIDX-1:0] rd;
  logic [5:0]      funct;
  logic [XLEN-1:0] imm;

  logic [XLEN-1:0] rd_a;
  logic [XLEN-1:0] rd_b;
  logic [RIDX-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_result;

  logic            pc_en;
  logic [XLEN-1:0] pc_next;

  // Instruction field extraction
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = {{16{ir_q[15]}}, ir_q[15:0]};

  // Register file read ports; r0 is hardwired to zero
  assign rd_a = (rs == '0) ? '0 : rf[rs];
  assign rd_b = (rt == '0) ? '0 : rf[rt];

  assign wr_addr = i_regdst ? rd : rt;
  assign wr_data = i_memtoreg ? mdr_q : aluout_q;

  // ALU operand selection
  always_comb begin
    src_a = i_alusrca ? a_q : pc_q;
    src_b = b_q;
    case (i_alusrcb)
      2'b00:   src_b = b_q;
      2'b01:   src_b = XLEN'(4);
      2'b10:   src_b = imm;
      default: src_b = {imm[XLEN-3:0], 2'b00};
    endcase
  end

  // ALU control decode from operation class and funct
  always_comb begin
    alu_op = ALU_ADD;
    case (i_aluop)
      2'b01: alu_op = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100010: alu_op = ALU_SUB;
          6'b100100: alu_op = ALU_AND;
          6'b100101: alu_op = ALU_OR;
          6'b101010: alu_op = ALU_SLT;
          default:   alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  // ALU; arithmetic wraps modulo 2^32 with no overflow trap
  always_comb begin
    alu_result = src_a + src_b;
    case (alu_op)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign o_zero = (alu_result == '0);

  // Next-PC selection; a branch shares the load path with an unconditional write
  always_comb begin
    pc_en   = i_pcwrite | (i_branch & o_zero);
    pc_next = pc_q;
    if (pc_en) begin
      case (i_pcsrc)
        2'b00:   pc_next = alu_result;
        2'b01:   pc_next = aluout_q;
        2'b10:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
        default: pc_next = pc_q;
      endcase
    end
  end

  // Architectural datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_next;
      mdr_q    <= i_mem_rdata;
      a_q      <= rd_a;
      b_q      <= rd_b;
      aluout_q <= alu_result;
      if (i_irwrite) begin
        ir_q <= i_mem_rdata;
      end
    end
  end

  // Register file write port; A/B see the pre-write value on a same-edge hit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (i_regwrite && (wr_addr != '0)) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign o_mem_addr  = i_iord ? aluout_q : pc_q;
  assign o_mem_wdata = b_q;
  assign o_mem_we    = i_memwrite;
  assign o_opcode    = ir_q[31:26];
  assign o_pc        = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Testbench for mc_datapath: directed instruction sequences then random strobes,
// checked against an architectural reference model.
module tb_mc_datapath;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_iord;
  logic        i_memwrite;
  logic        i_irwrite;
  logic        i_pcwrite;
  logic        i_branch;
  logic [1:0]  i_pcsrc;
  logic        i_regdst;
  logic        i_memtoreg;
  logic [1:0]  i_aluop;
  logic        i_alusrca;
  logic [1:0]  i_alusrcb;
  logic        i_regwrite;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [5:0]  o_opcode;
  logic        o_zero;
  logic [31:0] o_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  mc_datapath #(.RESET_PC(32'h0000_0000), .RF_DEPTH(32)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_iord      (i_iord),
    .i_memwrite  (i_memwrite),
    .i_irwrite   (i_irwrite),
    .i_pcwrite   (i_pcwrite),
    .i_branch    (i_branch),
    .i_pcsrc     (i_pcsrc),
    .i_regdst    (i_regdst),
    .i_memtoreg  (i_memtoreg),
    .i_aluop     (i_aluop),
    .i_alusrca   (i_alusrca),
    .i_alusrcb   (i_alusrcb),
    .i_regwrite  (i_regwrite),
    .i_mem_rdata (i_mem_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_opcode    (o_opcode),
    .o_zero      (o_zero),
    .o_pc        (o_pc)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value the ALU should produce from the model state and the current strobes
  function automatic logic [31:0] model_alu();
    logic [31:0] x, y, imm;
    imm = 32'($signed(m_ir[15:0]));
    x = i_alusrca ? m_a : m_pc;
    case (i_alusrcb)
      2'd0: y = m_b;
      2'd1: y = 32'd4;
      2'd2: y = imm;
      default: y = imm * 32'd4;
    endcase
    case (i_aluop)
      2'd1: return x - y;
      2'd2: begin
        case (m_ir[5:0])
          6'd34: return x - y;
          6'd36: return x & y;
          6'd37: return x | y;
          6'd42: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          default: return x + y;
        endcase
      end
      default: return x + y;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  // One rising edge of architectural behaviour
  task automatic model_clock();
    logic [31:0] res, npc, na, nb;
    int wa;
    res = model_alu();
    na  = m_rf[m_ir[25:21]];
    nb  = m_rf[m_ir[20:16]];
    npc = m_pc;
    if (i_pcwrite || (i_branch && res == 32'h0)) begin
      case (i_pcsrc)
        2'd0: npc = res;
        2'd1: npc = m_aluout;
        2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: npc = m_pc;
      endcase
    end
    if (i_regwrite) begin
      wa = i_regdst ? int'(m_ir[15:11]) : int'(m_ir[20:16]);
      if (wa != 0) m_rf[wa] = i_memtoreg ? m_mdr : m_aluout;
    end
    m_a = na;
    m_b = nb;
    m_mdr = i_mem_rdata;
    if (i_irwrite) m_ir = i_mem_rdata;
    m_aluout = res;
    m_pc = npc;
  endtask

  task automatic check_all();
    logic [31:0] res;
    res = model_alu();
    chk("pc", o_pc, m_pc);
    chk("opcode", {26'b0, o_opcode}, {26'b0, m_ir[31:26]});
    chk("mem_addr", o_mem_addr, i_iord ? m_aluout : m_pc);
    chk("mem_wdata", o_mem_wdata, m_b);
    chk("mem_we", {31'b0, o_mem_we}, {31'b0, i_memwrite});
    chk("zero", {31'b0, o_zero}, (res == 32'h0) ? 32'd1 : 32'd0);
  endtask

  task automatic ctl_clear();
    i_iord = 0; i_memwrite = 0; i_irwrite = 0; i_pcwrite = 0; i_branch = 0;
    i_pcsrc = 2'd0; i_regdst = 0; i_memtoreg = 0; i_aluop = 2'd0;
    i_alusrca = 0; i_alusrcb = 2'd0; i_regwrite = 0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic peek();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_pc_async", o_pc, 32'h0);
    chk("rst_opcode", {26'b0, o_opcode}, 32'h0);
    ctl_clear();
    @(posedge i_clk);
    #1;
    check_all();
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    ctl_clear(); i_irwrite = 1; i_mem_rdata = instr; tick();
    ctl_clear(); tick();
  endtask

  task automatic addi(input logic [4:0] rt, input logic [15:0] imm);
    load_ir({6'h08, 5'd0, rt, imm});
    ctl_clear(); i_alusrca = 1; i_alusrcb = 2'd2; tick();
    ctl_clear(); i_regwrite = 1; tick();
  endtask

  task automatic lw_into(input logic [4:0] rt, input logic [31:0] data);
    load_ir({6'h23, 5'd0, rt, 16'h0});
    ctl_clear(); i_iord = 1; i_mem_rdata = data; tick();
    ctl_clear(); i_memtoreg = 1; i_regwrite = 1; tick();
  endtask

  initial begin
    ctl_clear();
    i_mem_rdata = '0;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;

    // Put a value in r8 and move PC to 0x40, then reset mid-cycle
    addi(5'd8, 16'h0010);
    ctl_clear(); i_alusrcb = 2'd3; i_pcwrite = 1; tick();
    chk("pc_at_40", o_pc, 32'h40);
    do_reset();
    load_ir({6'h2b, 5'd0, 5'd8, 16'h0});
    chk("rf_cleared_by_reset", o_mem_wdata, 32'h0);

    // Fetch from PC = 8
    ctl_clear(); i_irwrite = 1; i_pcwrite = 1; i_alusrcb = 2'd1; i_mem_rdata = 32'h0; tick();
    tick();
    chk("pc_before_fetch", o_pc, 32'h8);
    i_mem_rdata = 32'h2008_0005; tick();
    chk("fetch_pc", o_pc, 32'hC);
    chk("fetch_opcode", {26'b0, o_opcode}, 32'h08);

    // ADDI r8 = r0 + 5
    ctl_clear(); tick();
    ctl_clear(); i_alusrca = 1; i_alusrcb = 2'd2; tick();
    ctl_clear(); i_regwrite = 1; tick();
    ctl_clear(); tick();
    chk("addi_r8", o_mem_wdata, 32'h5);
    addi(5'd0, 16'h0005);
    ctl_clear(); tick();
    chk("addi_r0", o_mem_wdata, 32'h0);

    // BEQ taken / not taken
    do_reset();
    addi(5'd9, 16'h0007);
    addi(5'd10, 16'h0007);
    addi(5'd11, 16'h0008);
    load_ir({6'h04, 5'd9, 5'd10, 16'h0040});
    ctl_clear(); i_alusrcb = 2'd3; tick();
    ctl_clear(); i_alusrca = 1; i_aluop = 2'd1; i_branch = 1; i_pcsrc = 2'd1;
    peek();
    chk("beq_zero", {31'b0, o_zero}, 32'd1);
    tick();
    chk("beq_taken_pc", o_pc, 32'h100);
    load_ir({6'h04, 5'd9, 5'd11, 16'h0040});
    ctl_clear(); i_alusrcb = 2'd3; tick();
    ctl_clear(); i_alusrca = 1; i_aluop = 2'd1; i_branch = 1; i_pcsrc = 2'd1; tick();
    chk("beq_not_taken_pc", o_pc, 32'h100);

    // SLT signed, then ADD of the same operands
    addi(5'd12, 16'hFFFF);
    addi(5'd13, 16'h0001);
    load_ir({6'h00, 5'd12, 5'd13, 5'd0, 5'd0, 6'h2a});
    ctl_clear(); i_alusrca = 1; i_aluop = 2'd2; tick();
    ctl_clear(); i_iord = 1; peek();
    chk("slt_aluout", o_mem_addr, 32'h1);
    tick();
    load_ir({6'h00, 5'd12, 5'd13, 5'd0, 5'd0, 6'h20});
    ctl_clear(); i_alusrca = 1; i_aluop = 2'd2; peek();
    chk("add_zero", {31'b0, o_zero}, 32'd1);
    tick();
    ctl_clear(); i_iord = 1; peek();
    chk("add_aluout", o_mem_addr, 32'h0);
    tick();

    // LW then SW of the loaded word
    lw_into(5'd14, 32'hDEAD_BEEF);
    load_ir({6'h2b, 5'd0, 5'd14, 16'h0020});
    ctl_clear(); i_alusrca = 1; i_alusrcb = 2'd2; tick();
    ctl_clear(); i_iord = 1; i_memwrite = 1; peek();
    chk("sw_addr", o_mem_addr, 32'h20);
    chk("sw_we", {31'b0, o_mem_we}, 32'd1);
    chk("sw_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    tick();
    ctl_clear(); peek();
    chk("we_one_cycle", {31'b0, o_mem_we}, 32'd0);

    // Jump keeps PC[31:28]
    lw_into(5'd16, 32'h1000_0000);
    load_ir({6'h00, 5'd16, 5'd0, 16'h0000});
    ctl_clear(); i_alusrca = 1; i_alusrcb = 2'd2; i_pcwrite = 1; tick();
    chk("pc_1000", o_pc, 32'h1000_0000);
    ctl_clear(); i_irwrite = 1; i_mem_rdata = 32'h0800_0003; tick();
    ctl_clear(); i_pcwrite = 1; i_pcsrc = 2'd2; tick();
    chk("jump_pc", o_pc, 32'h1000_000C);

    // PC + 4 wraps at the top of the address space
    do_reset();
    ctl_clear(); i_irwrite = 1; i_mem_rdata = {6'h08, 5'd0, 5'd0, 16'hFFFC}; tick();
    ctl_clear(); i_alusrcb = 2'd2; i_pcwrite = 1; tick();
    chk("pc_top", o_pc, 32'hFFFF_FFFC);
    ctl_clear(); i_alusrcb = 2'd1; i_pcwrite = 1; tick();
    chk("pc_wrap", o_pc, 32'h0);

    // Random strobes and memory data
    for (int n = 0; n < 400; n++) begin
      i_iord      = 1'($urandom);
      i_memwrite  = 1'($urandom);
      i_irwrite   = 1'($urandom);
      i_pcwrite   = ($urandom_range(0, 3) == 0);
      i_branch    = 1'($urandom);
      i_pcsrc     = 2'($urandom);
      i_regdst    = 1'($urandom);
      i_memtoreg  = 1'($urandom);
      i_aluop     = 2'($urandom);
      i_alusrca   = 1'($urandom);
      i_alusrcb   = 2'($urandom);
      i_regwrite  = 1'($urandom);
      i_mem_rdata = (($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom));
      peek();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
